cpu_mem_arbiter: RTL and testbench
==================================

# cpu_mem_arbiter

Memory-side responder for the CPU datapath's two memory ports: port A (instruction fetch) and port B (data load/store). It accepts requests on both ports and serializes them onto a single downstream memory port that uses the same handshake. It returns a one-cycle `resp` with read data to whichever CPU port was served. It sits between the pipelined CPU and the physical memory or cache.

## Interface
- FAIR, default 0: 0 = port B has fixed priority on a simultaneous request; 1 = round-robin between A and B.
- clk  in  1  Rising-edge clock.
- rst_n  in  1  Synchronous reset, active low.
- read_a, write_a  in  1 each  Port A request strobes; held until `resp_a`.
- wmask_a  in  2  Port A byte mask.
- address_a  in  16  Port A address.
- wdata_a  in  16  Port A write data.
- resp_a  out  1  One-cycle completion pulse for port A.
- rdata_a  out  16  Port A read data; valid while `resp_a`=1.
- read_b, write_b, wmask_b, address_b, wdata_b, resp_b, rdata_b: same as port A, for port B.
- mem_read, mem_write  out  1 each  Downstream request strobes.
- mem_wmask  out  2  Downstream byte mask.
- mem_address  out  16  Downstream address.
- mem_wdata  out  16  Downstream write data.
- mem_resp  in  1  Downstream completion pulse.
- mem_rdata  in  16  Downstream read data; valid while `mem_resp`=1.

## Operation
- **States:**
  - IDLE: sample requests.
  - BUSY: downstream transaction outstanding.
  - RESP: pulse `resp` to the served port.
- **IDLE:**
  - A port is requesting if `read_x` or `write_x` is high.
  - Only one port requesting: grant it.
  - Both requesting, FAIR=0: grant B.
  - Both requesting, FAIR=1: grant the port not granted last. `last_grant` resets to B, so the first tie goes to A.
  - On a grant, register the granted port's address, wdata, wmask and op into the `mem_*` outputs, record the grant, and go to BUSY.
- **Op encoding:**
  - If `write_x`=1: the op is a write, even if `read_x` is also 1. `mem_write`=1, `mem_read`=0, `mem_wmask`=`wmask_x`.
  - Otherwise the op is a read. `mem_read`=1, `mem_write`=0, `mem_wmask`=2'b00.
- **BUSY:**
  - `mem_*` outputs hold constant.
  - On `mem_resp`=1: capture `mem_rdata` into `rdata_x` (read ops only), clear `mem_read`/`mem_write`, go to RESP.
- **RESP:**
  - `resp_x`=1 for exactly this cycle, with `rdata_x` valid.
  - The served port still holds its request this cycle; it is not re-sampled.
  - Next state is IDLE.
- **rdata_x:** holds its last captured value between responses; writes do not change it.
- **Ignored input:** `mem_resp` is ignored in IDLE and RESP.
- **Exclusivity:** `resp_a` and `resp_b` are never high in the same cycle.
- **Reset** (rst_n=0 at an edge):
  - State returns to IDLE; `last_grant` = B.
  - All outputs (`resp_*`, `rdata_*`, all `mem_*`) go to 0.
  - Any in-flight downstream transaction is abandoned with no `resp` to the CPU. A late `mem_resp` arriving after reset is ignored.

## Timing
- `mem_*` outputs are registered: a request sampled in IDLE at cycle 0 drives `mem_read`/`mem_write` from cycle 1.
- **Latency:** if `mem_resp` arrives in cycle k (k≥1), `resp_x` is high in cycle k+1.
  - Minimum request-to-`resp` latency is 2 cycles (zero-wait memory).
  - Total latency is 2 + downstream wait cycles.
- **Back-to-back:** the next grant is sampled in IDLE at cycle k+2.
  - A port that keeps its strobe high after `resp` is treated as issuing a new request.
  - Minimum occupancy is 3 cycles per transaction.
- **Starvation bound:**
  - FAIR=1: a waiting port is served after at most one transaction of the other port.
  - FAIR=0: port A can starve if port B requests continuously.

## Test plan
- **Single read on A:** `read_a`=1, `address_a`=0x0040; memory answers `mem_resp` 2 cycles after `mem_read` with 0xBEEF. Required:
  - `mem_address`=0x0040 from cycle 1.
  - `resp_a`=1 for one cycle at cycle 4, with `rdata_a`=0xBEEF.
  - `resp_b` stays 0 throughout.
- **Write on B:** `write_b`=1, `address_b`=0x1000, `wdata_b`=0x1234, `wmask_b`=2'b01, zero-wait memory. Required:
  - `mem_write`=1, `mem_wdata`=0x1234, `mem_wmask`=2'b01.
  - `resp_b` at cycle 2.
  - `rdata_b` unchanged.
- **Simultaneous A/B, FAIR=0:** both request from cycle 0. Required: B served first, then A granted at B's resp cycle + 1, so two `resp` pulses in order B then A.
- **Simultaneous A/B, FAIR=1, both held for 4 transactions:** required grant order A, B, A, B.
- **Reset mid-operation:** drop `rst_n` for one cycle while in BUSY, then deliver `mem_resp`. Required:
  - All outputs are 0 after the reset edge.
  - No `resp_a`/`resp_b` pulse occurs.
  - The stale `mem_resp` is ignored.
- **Read and write both high on one port:** `read_a`=`write_a`=1. Required: `mem_write`=1, `mem_read`=0.

Source files
------------

// File: rtl/cpu_mem_arbiter_if.sv
// Request/response handshake shared by the CPU memory ports and the downstream memory port.
// The requester uses the master modport; the responder uses the slave modport.
interface cpu_mem_arbiter_if;
    logic        read;
    logic        write;
    logic [1:0]  wmask;
    logic [15:0] address;
    logic [15:0] wdata;
    logic        resp;
    logic [15:0] rdata;

    modport master (output read, write, wmask, address, wdata, input resp, rdata);
    modport slave  (input read, write, wmask, address, wdata, output resp, rdata);
endinterface

// File: rtl/cpu_mem_arbiter.sv
// Serializes the CPU instruction-fetch port (A) and data port (B) onto one downstream memory port.
// B wins ties unless FAIR is set, in which case ties alternate starting with A.
module cpu_mem_arbiter #(
    parameter bit FAIR = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    cpu_mem_arbiter_if.slave  port_a,
    cpu_mem_arbiter_if.slave  port_b,
    cpu_mem_arbiter_if.master mem
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic {PORT_A, PORT_B} port_t;

    state_t      state;
    port_t       served;
    port_t       last_grant;
    port_t       grant;
    logic        req_a;
    logic        req_b;
    logic        sel_write;
    logic [1:0]  sel_wmask;
    logic [15:0] sel_address;
    logic [15:0] sel_wdata;

    assign req_a = port_a.read | port_a.write;
    assign req_b = port_b.read | port_b.write;

    always_comb begin
        // NOTE: grant gets a default before any condition so no path leaves it unassigned (no latch).
        grant = PORT_B;
        if (req_a && (!req_b || (FAIR && last_grant == PORT_B)))
            grant = PORT_A;
    end

    assign sel_write   = (grant == PORT_A) ? port_a.write   : port_b.write;
    assign sel_wmask   = (grant == PORT_A) ? port_a.wmask   : port_b.wmask;
    assign sel_address = (grant == PORT_A) ? port_a.address : port_b.address;
    assign sel_wdata   = (grant == PORT_A) ? port_a.wdata   : port_b.wdata;

    // NOTE: all state and outputs use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            served       <= PORT_A;
            last_grant   <= PORT_B;
            mem.read     <= 1'b0;
            mem.write    <= 1'b0;
            mem.wmask    <= 2'b00;
            mem.address  <= 16'h0000;
            mem.wdata    <= 16'h0000;
            port_a.resp  <= 1'b0;
            port_a.rdata <= 16'h0000;
            port_b.resp  <= 1'b0;
            port_b.rdata <= 16'h0000;
        end else begin
            port_a.resp <= 1'b0;
            port_b.resp <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_a || req_b) begin
                        served      <= grant;
                        last_grant  <= grant;
                        mem.write   <= sel_write;
                        mem.read    <= ~sel_write;
                        mem.wmask   <= sel_write ? sel_wmask : 2'b00;
                        mem.address <= sel_address;
                        mem.wdata   <= sel_wdata;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem.resp) begin
                        mem.read  <= 1'b0;
                        mem.write <= 1'b0;
                        state     <= RESP;
                        // rdata only tracks reads; a write leaves the last value visible.
                        if (served == PORT_A) begin
                            port_a.resp <= 1'b1;
                            if (mem.read) port_a.rdata <= mem.rdata;
                        end else begin
                            port_b.resp <= 1'b1;
                            if (mem.read) port_b.rdata <= mem.rdata;
                        end
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Scoreboard bench: two arbiters (FAIR=0 and FAIR=1) driven with the same CPU traffic,
// each with its own behavioural downstream memory; expected service order is queued per DUT.
module tb_cpu_mem_arbiter;
  typedef struct {
    bit          port;
    bit          rd;
    bit          wr;
    logic [1:0]  mask;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mem_wait = 0;

  txn_t        cpu_q[4][$];
  txn_t        exp_q[2][$];
  txn_t        drv[4];
  logic [15:0] last_rdata[4];
  logic        stale[2];
  int          resp_cyc[2][16];
  int          resp_n[2];

  logic        resp_s[4];
  logic [15:0] rdata_s[4];
  logic        mrd[2];
  logic        mwr[2];
  logic [1:0]  mmask[2];
  logic [15:0] maddr[2];
  logic [15:0] mwdata[2];

  function automatic logic [15:0] mem_data(input logic [15:0] a);
    return (a == 16'h0040) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  function automatic txn_t mk(input bit p, input bit rd, input bit wr, input logic [1:0] mask,
                              input logic [15:0] addr, input logic [15:0] wdata);
    txn_t t;
    t.port = p; t.rd = rd; t.wr = wr; t.mask = mask;
    t.addr = addr; t.wdata = wdata; t.rdata = 16'h0000;
    return t;
  endfunction

  for (genvar d = 0; d < 2; d++) begin : g
    cpu_mem_arbiter_if pa();
    cpu_mem_arbiter_if pb();
    cpu_mem_arbiter_if pm();
    int cnt;

    cpu_mem_arbiter #(.FAIR(d == 1)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .port_a (pa),
      .port_b (pb),
      .mem    (pm)
    );

    assign pa.read    = drv[2*d].rd;
    assign pa.write   = drv[2*d].wr;
    assign pa.wmask   = drv[2*d].mask;
    assign pa.address = drv[2*d].addr;
    assign pa.wdata   = drv[2*d].wdata;
    assign pb.read    = drv[2*d+1].rd;
    assign pb.write   = drv[2*d+1].wr;
    assign pb.wmask   = drv[2*d+1].mask;
    assign pb.address = drv[2*d+1].addr;
    assign pb.wdata   = drv[2*d+1].wdata;

    // Memory answers after mem_wait cycles of an asserted strobe; stale[] injects a stray pulse.
    always @(posedge clk) cnt <= (pm.read || pm.write) ? cnt + 1 : 0;
    assign pm.resp  = ((pm.read || pm.write) && cnt == mem_wait) || stale[d];
    assign pm.rdata = pm.resp ? mem_data(pm.address) : 16'hDEAD;
  end

  task automatic sample();
    resp_s[0] = g[0].pa.resp;  rdata_s[0] = g[0].pa.rdata;
    resp_s[1] = g[0].pb.resp;  rdata_s[1] = g[0].pb.rdata;
    resp_s[2] = g[1].pa.resp;  rdata_s[2] = g[1].pa.rdata;
    resp_s[3] = g[1].pb.resp;  rdata_s[3] = g[1].pb.rdata;
    mrd[0] = g[0].pm.read;  mwr[0] = g[0].pm.write;  mmask[0] = g[0].pm.wmask;
    maddr[0] = g[0].pm.address;  mwdata[0] = g[0].pm.wdata;
    mrd[1] = g[1].pm.read;  mwr[1] = g[1].pm.write;  mmask[1] = g[1].pm.wmask;
    maddr[1] = g[1].pm.address;  mwdata[1] = g[1].pm.wdata;
  endtask

  function automatic void expect_txn(input int d, input txn_t t);
    txn_t e = t;
    if (!e.wr) begin
      e.rdata = mem_data(e.addr);
      last_rdata[2*d+e.port] = e.rdata;
    end else begin
      e.rdata = last_rdata[2*d+e.port];
    end
    exp_q[d].push_back(e);
  endfunction

  function automatic void issue(input int d, input txn_t t, input bit scored);
    cpu_q[2*d+t.port].push_back(t);
    if (scored) expect_txn(d, t);
  endfunction

  function automatic bit busy();
    for (int i = 0; i < 4; i++) if (cpu_q[i].size() != 0) return 1'b1;
    for (int d = 0; d < 2; d++) if (exp_q[d].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void flush();
    for (int i = 0; i < 4; i++) begin
      cpu_q[i].delete();
      drv[i] = mk(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    end
    for (int d = 0; d < 2; d++) exp_q[d].delete();
  endfunction

  // One clock: sample mid-cycle, score mem requests and responses, then update CPU drivers.
  task automatic step();
    txn_t e;
    logic [35:0] got_req, exp_req;
    @(negedge clk);
    #1;
    cyc++;
    sample();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (resp_s[2*d] && resp_s[2*d+1]) begin
        failures++;
        $display("FAIL resp_exclusive dut%0d: got resp_a=1 resp_b=1, required at most one", d);
      end
      if (mrd[d] || mwr[d]) begin
        checks++;
        if (exp_q[d].size() == 0) begin
          failures++;
          $display("FAIL mem_unexpected dut%0d: got request addr=%h, required none", d, maddr[d]);
        end else begin
          e = exp_q[d][0];
          got_req = {mrd[d], mwr[d], mmask[d], maddr[d], mwdata[d]};
          exp_req = {~e.wr, e.wr, (e.wr ? e.mask : 2'b00), e.addr, e.wdata};
          if (got_req !== exp_req) begin
            failures++;
            $display("FAIL mem_request dut%0d cyc%0d: got %h, required %h", d, cyc, got_req, exp_req);
          end
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (resp_s[2*d+p]) begin
          checks++;
          if (exp_q[d].size() == 0) begin
            failures++;
            $display("FAIL resp_spurious dut%0d: got resp on port %0d, required none", d, p);
          end else begin
            e = exp_q[d].pop_front();
            if ((p == 1) != e.port || rdata_s[2*d+p] !== e.rdata) begin
              failures++;
              $display("FAIL resp_data dut%0d: got port=%0d rdata=%h, required port=%0d rdata=%h",
                       d, p, rdata_s[2*d+p], e.port, e.rdata);
            end
            if (cpu_q[2*d+p].size() != 0) void'(cpu_q[2*d+p].pop_front());
            if (resp_n[d] < 16) begin
              resp_cyc[d][resp_n[d]] = cyc;
              resp_n[d]++;
            end
          end
        end
      end
      for (int p = 0; p < 2; p++)
        drv[2*d+p] = (cpu_q[2*d+p].size() != 0) ? cpu_q[2*d+p][0]
                                                : mk(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    end
  endtask

  task automatic run_until_done(input string name, input int budget);
    int n = 0;
    while (busy() && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (busy()) begin
      failures++;
      $display("FAIL %s timeout: got work pending after %0d cycles, required drained", name, budget);
      flush();
    end
    repeat (2) step();
  endtask

  task automatic check_all_zero(input string name);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({mrd[d], mwr[d], mmask[d], maddr[d], mwdata[d], resp_s[2*d], resp_s[2*d+1],
           rdata_s[2*d], rdata_s[2*d+1]} !== '0) begin
        failures++;
        $display("FAIL %s dut%0d: got mem=%b%b %h %h %h resp=%b%b rdata=%h %h, required all 0",
                 name, d, mrd[d], mwr[d], mmask[d], maddr[d], mwdata[d],
                 resp_s[2*d], resp_s[2*d+1], rdata_s[2*d], rdata_s[2*d+1]);
      end
    end
  endtask

  task automatic clear_log();
    resp_n[0] = 0;
    resp_n[1] = 0;
  endtask

  task automatic check_gaps(input string name, input int count, input int gap);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (resp_n[d] != count) begin
        failures++;
        $display("FAIL %s_count dut%0d: got %0d responses, required %0d", name, d, resp_n[d], count);
      end else begin
        for (int i = 1; i < count; i++) begin
          checks++;
          if (resp_cyc[d][i] - resp_cyc[d][i-1] != gap) begin
            failures++;
            $display("FAIL %s_gap dut%0d #%0d: got %0d cycles, required %0d",
                     name, d, i, resp_cyc[d][i] - resp_cyc[d][i-1], gap);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    check_all_zero("reset_outputs");
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_read();
    mem_wait = 2;
    for (int d = 0; d < 2; d++) issue(d, mk(1'b0, 1'b1, 1'b0, 2'b00, 16'h0040, 16'h0000), 1'b1);
    step();
    for (int k = 1; k <= 6; k++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (resp_s[2*d] !== (k == 4) || resp_s[2*d+1] !== 1'b0) begin
          failures++;
          $display("FAIL single_read_resp dut%0d cycle%0d: got resp_a=%b resp_b=%b, required %b 0",
                   d, k, resp_s[2*d], resp_s[2*d+1], k == 4);
        end
        if (k <= 3) begin
          checks++;
          if (mrd[d] !== 1'b1 || maddr[d] !== 16'h0040) begin
            failures++;
            $display("FAIL single_read_mem dut%0d cycle%0d: got read=%b addr=%h, required 1 0040",
                     d, k, mrd[d], maddr[d]);
          end
        end
        if (k == 4) begin
          checks++;
          if (rdata_s[2*d] !== 16'hBEEF) begin
            failures++;
            $display("FAIL single_read_rdata dut%0d: got %h, required beef", d, rdata_s[2*d]);
          end
        end
      end
    end
    run_until_done("single_read", 20);
  endtask

  task automatic test_write_b();
    mem_wait = 0;
    for (int d = 0; d < 2; d++) issue(d, mk(1'b1, 1'b0, 1'b1, 2'b01, 16'h1000, 16'h1234), 1'b1);
    step();
    for (int k = 1; k <= 4; k++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (resp_s[2*d+1] !== (k == 2) || resp_s[2*d] !== 1'b0) begin
          failures++;
          $display("FAIL write_b_resp dut%0d cycle%0d: got resp_a=%b resp_b=%b, required 0 %b",
                   d, k, resp_s[2*d], resp_s[2*d+1], k == 2);
        end
        if (k == 1) begin
          checks++;
          if ({mwr[d], mrd[d], mwdata[d], mmask[d]} !== {1'b1, 1'b0, 16'h1234, 2'b01}) begin
            failures++;
            $display("FAIL write_b_mem dut%0d: got wr=%b rd=%b wdata=%h mask=%b, required 1 0 1234 01",
                     d, mwr[d], mrd[d], mwdata[d], mmask[d]);
          end
        end
        if (k == 2) begin
          checks++;
          if (rdata_s[2*d+1] !== last_rdata[2*d+1]) begin
            failures++;
            $display("FAIL write_b_rdata dut%0d: got %h, required %h", d, rdata_s[2*d+1], last_rdata[2*d+1]);
          end
        end
      end
    end
    run_until_done("write_b", 20);
  endtask

  task automatic test_read_write_both();
    mem_wait = 1;
    for (int d = 0; d < 2; d++) issue(d, mk(1'b0, 1'b1, 1'b1, 2'b10, 16'h0200, 16'hCAFE), 1'b1);
    step();
    step();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (mwr[d] !== 1'b1 || mrd[d] !== 1'b0) begin
        failures++;
        $display("FAIL rw_both_op dut%0d: got wr=%b rd=%b, required 1 0", d, mwr[d], mrd[d]);
      end
    end
    run_until_done("rw_both", 20);
  endtask

  task automatic test_reset_mid();
    mem_wait = 5;
    for (int d = 0; d < 2; d++) issue(d, mk(1'b0, 1'b1, 1'b0, 2'b00, 16'h0300, 16'h0000), 1'b1);
    repeat (3) step();
    flush();
    for (int i = 0; i < 4; i++) last_rdata[i] = 16'h0000;
    rst_n = 1'b0;
    step();
    check_all_zero("reset_mid_outputs");
    rst_n = 1'b1;
    stale[0] = 1'b1;
    stale[1] = 1'b1;
    step();
    stale[0] = 1'b0;
    stale[1] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      check_all_zero("reset_mid_stale");
    end
  endtask

  task automatic test_simultaneous();
    txn_t a1, a2, b1, b2;
    mem_wait = 1;
    clear_log();
    a1 = mk(1'b0, 1'b1, 1'b0, 2'b00, 16'h0400, 16'h0000);
    a2 = mk(1'b0, 1'b1, 1'b0, 2'b00, 16'h0402, 16'h0000);
    b1 = mk(1'b1, 1'b1, 1'b0, 2'b00, 16'h0500, 16'h0000);
    b2 = mk(1'b1, 1'b0, 1'b1, 2'b11, 16'h0502, 16'h7777);
    for (int d = 0; d < 2; d++) begin
      issue(d, a1, 1'b0); issue(d, a2, 1'b0);
      issue(d, b1, 1'b0); issue(d, b2, 1'b0);
    end
    expect_txn(0, b1); expect_txn(0, b2); expect_txn(0, a1); expect_txn(0, a2);
    expect_txn(1, a1); expect_txn(1, b1); expect_txn(1, a2); expect_txn(1, b2);
    run_until_done("simultaneous", 60);
    check_gaps("simultaneous", 4, 4);
  endtask

  task automatic test_back_to_back();
    mem_wait = 0;
    clear_log();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 3; i++)
        issue(d, mk(1'b1, 1'b1, 1'b0, 2'b00, 16'h0800 + 16'(2*i), 16'h0000), 1'b1);
    run_until_done("back_to_back", 40);
    check_gaps("back_to_back", 3, 3);
  endtask

  initial begin
    stale[0] = 1'b0;
    stale[1] = 1'b0;
    for (int i = 0; i < 4; i++) last_rdata[i] = 16'h0000;
    flush();
    clear_log();
    test_reset();
    test_single_read();
    test_write_b();
    test_read_write_both();
    test_reset_mid();
    test_simultaneous();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
